// File: rtl/jnw_ana_seq_if.sv
// Config register bus for the analog channel sequencer: write strobe/address/data
// toward the sequencer, combinational readback from it.
interface jnw_ana_seq_if;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output we, output addr, output wdata, input  rdata);
  modport slave  (input  we, input  addr, input  wdata, output rdata);
endinterface

// File: rtl/jnw_ana_seq.sv
// Analog channel sequencer: break-before-make sweep over up to four masked channels,
// settle, sample strobe, 1-bit capture. Define JNW_ANA_SEQ_CONT_EN for continuous sweeps.
module jnw_ana_seq #(
  parameter int SW = 8
) (
  input  logic             clk,
  input  logic             rst,
  jnw_ana_seq_if.slave     cfg,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic [3:0]       ch_sel,
  output logic             sample,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_SETTLE, ST_SAMPLE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cur_q, cur_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [3:0]    result_q, result_d;
  logic          done_d;

  logic [3:0]    mask_q;
  logic [SW-1:0] settle_q, settle_ld;
  logic          cont;
  logic          wr_ok;
  logic          unused_wdata;

  assign wr_ok        = cfg.we && !busy;
  assign settle_ld    = (settle_q == '0) ? SW'(1) : settle_q;
  assign unused_wdata = ^cfg.wdata;

  // ---- config registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q   <= '0;
      settle_q <= '0;
    end else if (wr_ok) begin
      if (cfg.addr == 2'd0) mask_q   <= cfg.wdata[3:0];
      if (cfg.addr == 2'd1) settle_q <= cfg.wdata[SW-1:0];
    end
  end

`ifdef JNW_ANA_SEQ_CONT_EN
  always_ff @(posedge clk) begin
    if (rst)                             cont <= 1'b0;
    else if (wr_ok && cfg.addr == 2'd0)  cont <= cfg.wdata[7];
  end
`else
  assign cont = 1'b0;
`endif

  always_comb begin
    cfg.rdata = '0;
    case (cfg.addr)
      2'd0: cfg.rdata = {cont, 3'b000, mask_q};
      2'd1: cfg.rdata = 8'(settle_q);
      2'd2: cfg.rdata = {4'b0000, result_q};
      2'd3: cfg.rdata = {7'b0000000, busy};
      default: cfg.rdata = '0;
    endcase
  end

  // ---- channel search: lowest set mask bit, next set bit above cur ----
  logic [1:0] lo_idx, up_idx;
  logic       up_vld;

  always_comb begin
    lo_idx = '0;
    up_idx = '0;
    up_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i]) lo_idx = 2'(i);
      if (mask_q[i] && i > int'(cur_q)) begin
        up_idx = 2'(i);
        up_vld = 1'b1;
      end
    end
  end

  // ---- sweep FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mask_q != '0) begin
            state_d  = ST_BREAK;
            cur_d    = lo_idx;
            result_d = result_q & mask_q;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        cnt_d   = settle_ld;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q <= SW'(1)) state_d = ST_SAMPLE;
        else                 cnt_d   = cnt_q - SW'(1);
      end
      ST_SAMPLE: begin
        result_d[cur_q] = cmp_in;
        if (up_vld) begin
          cur_d   = up_idx;
          state_d = ST_BREAK;
        end else begin
          done_d  = 1'b1;
          // continuous mode wraps to the lowest channel; done marks each completed sweep
          if (cont) begin
            cur_d   = lo_idx;
            state_d = ST_BREAK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // abort wins over everything, including the capture in SAMPLE
    if (abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_sel <= '0;
      sample <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ch_sel <= (state_d == ST_SETTLE || state_d == ST_SAMPLE) ? (4'b0001 << cur_d) : 4'b0000;
      sample <= (state_d == ST_SAMPLE);
      busy   <= (state_d != ST_IDLE);
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_jnw_ana_seq.sv
// Scoreboard bench for jnw_ana_seq: stimulus pushes expected sample/done events,
// a negedge monitor pops and compares them.
module tb_jnw_ana_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, cmp_in = 1'b0;
  logic [3:0] ch_sel;
  logic       sample, busy, done;

  jnw_ana_seq_if cfg();

  jnw_ana_seq #(.SW(8)) dut (
    .clk(clk), .rst(rst), .cfg(cfg), .start(start), .abort(abort), .cmp_in(cmp_in),
    .ch_sel(ch_sel), .sample(sample), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // kind 0: sample strobe, val = expected ch_sel; kind 1: done, val = expected result readback
  typedef struct packed { logic kind; logic [7:0] val; } ev_t;
  ev_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  // ---- monitor ----
  logic [3:0] prev_ch = '0;
  always @(negedge clk) begin
    ev_t e;
    chk("onehot", 8'($countones(ch_sel) <= 1), 8'd1);
    chk("bbm", 8'(!(prev_ch != 0 && ch_sel != 0 && ch_sel != prev_ch)), 8'd1);
    prev_ch = ch_sel;
    if (sample) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sample_unexpected: got ch_sel %h want no event", ch_sel);
      end else begin
        e = q.pop_front();
        chk("sample_kind", 8'(e.kind), 8'd0);
        chk("sample_ch", 8'(ch_sel), e.val);
      end
    end
    if (done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got done result %h want no event", cfg.rdata);
      end else begin
        e = q.pop_front();
        chk("done_kind", 8'(e.kind), 8'd1);
        chk("done_result", cfg.rdata, e.val);
      end
    end
  end

  // ---- stimulus helpers (called just after a posedge) ----
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg.we = 1'b1; cfg.addr = a; cfg.wdata = d;
    @(posedge clk); #1;
    cfg.we = 1'b0; cfg.addr = 2'd2;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [7:0] exp);
    cfg.addr = a; #1;
    chk(nm, cfg.rdata, exp);
    cfg.addr = 2'd2;
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  logic [3:0] seq1 [11] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
  int bcnt, dcnt;

  initial begin
    cfg.we = 1'b0; cfg.addr = 2'd2; cfg.wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    rd("rst_addr0", 2'd0, 8'h00);
    rd("rst_addr1", 2'd1, 8'h00);
    rd("rst_addr2", 2'd2, 8'h00);
    rd("rst_addr3", 2'd3, 8'h00);
    chk("rst_ch_sel", 8'(ch_sel), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);

    // mask 0x5, settle 3, cmp 1
    wr(2'd0, 8'h05); wr(2'd1, 8'd3);
    cmp_in = 1'b1;
    push(0, 8'h1); push(0, 8'h4); push(1, 8'h05);
    kick();
    bcnt = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      chk($sformatf("seq1_ch_c%0d", c + 1), 8'(ch_sel), 8'(seq1[c]));
      bcnt += int'(busy);
    end
    chk("seq1_busy_cycles", 8'(bcnt), 8'd10);
    @(posedge clk); #1;
    rd("seq1_result", 2'd2, 8'h05);

    // mask 0xF, settle 0, cmp toggling: samples close at e0+3,6,9,12 -> 0,1,0,1
    wr(2'd0, 8'h0F); wr(2'd1, 8'd0);
    push(0, 8'h1); push(0, 8'h2); push(0, 8'h4); push(0, 8'h8); push(1, 8'h0A);
    cmp_in = 1'b1;
    kick();
    for (int j = 1; j <= 13; j++) begin
      cmp_in = (j % 2 == 0);
      @(posedge clk); #1;
    end
    rd("tog_result", 2'd2, 8'h0A);
    chk("tog_busy_end", 8'(busy), 8'h00);

    // abort during SAMPLE of channel 2: bits 1:0 captured, bit 2 kept, bit 3 kept
    cmp_in = 1'b1;
    push(0, 8'h1); push(0, 8'h2); push(0, 8'h4);
    kick();
    repeat (8) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_ch_sel", 8'(ch_sel), 8'h00);
    chk("abort_busy", 8'(busy), 8'h00);
    chk("abort_sample", 8'(sample), 8'h00);
    repeat (2) @(posedge clk); #1;
    rd("abort_result", 2'd2, 8'h0B);

    // mask 0: done next cycle, busy never high, result unchanged
    wr(2'd0, 8'h00);
    push(1, 8'h0B);
    kick();
    @(negedge clk);
    chk("mask0_busy", 8'(busy), 8'h00);
    chk("mask0_done", 8'(done), 8'h01);
    @(posedge clk); #1;
    chk("mask0_busy2", 8'(busy), 8'h00);

    // writes while busy are dropped
    wr(2'd0, 8'h01); wr(2'd1, 8'd2);
    cmp_in = 1'b0;
    push(0, 8'h1); push(1, 8'h00);
    kick();
    wr(2'd1, 8'd7);
    wr(2'd0, 8'h0F);
    repeat (4) @(posedge clk); #1;
    rd("busy_wr_settle", 2'd1, 8'd2);
    rd("busy_wr_mask", 2'd0, 8'h01);

    // continuous mode: cont=1, mask 0x2, settle 1
    wr(2'd0, 8'h82); wr(2'd1, 8'd1);
    cmp_in = 1'b1;
`ifdef JNW_ANA_SEQ_CONT_EN
    rd("cont_addr0", 2'd0, 8'h82);
    repeat (3) begin push(0, 8'h2); push(1, 8'h02); end
`else
    rd("cont_addr0", 2'd0, 8'h02);
    push(0, 8'h2); push(1, 8'h02);
`endif
    kick();
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bcnt += int'(busy);
      dcnt += int'(done);
    end
`ifdef JNW_ANA_SEQ_CONT_EN
    chk("cont_busy_cycles", 8'(bcnt), 8'd10);
    chk("cont_done_count", 8'(dcnt), 8'd3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("cont_abort_busy", 8'(busy), 8'h00);
    chk("cont_abort_ch", 8'(ch_sel), 8'h00);
`else
    chk("cont_busy_cycles", 8'(bcnt), 8'd3);
    chk("cont_done_count", 8'(dcnt), 8'd1);
    @(posedge clk); #1;
`endif
    wr(2'd0, 8'h00);

    // reset mid-sweep
    wr(2'd0, 8'h01); wr(2'd1, 8'd5);
    kick();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ch_sel", 8'(ch_sel), 8'h00);
    chk("midrst_busy", 8'(busy), 8'h00);
    chk("midrst_sample", 8'(sample), 8'h00);
    chk("midrst_done", 8'(done), 8'h00);
    rst = 1'b0;
    rd("midrst_addr0", 2'd0, 8'h00);
    rd("midrst_addr1", 2'd1, 8'h00);
    rd("midrst_addr2", 2'd2, 8'h00);

    repeat (2) @(posedge clk); #1;
    chk("scoreboard_empty", 8'(q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jnw_ana_seq.md
# jnw_ana_seq

Analog channel sequencer for the Tiny Tapeout analog tile. Time-multiplexes up to four analog channels onto the shared measurement path by driving one-hot switch enables with break-before-make. For each enabled channel it waits a programmable settle time, strobes a sample, and captures the 1-bit comparator result. Sits between the digital config interface (`ui_in`/`uio_in` decode) and the analog macro's switch and sample controls.

## Interface
- `SW`, default 8: settle counter width; range 1..8; `cfg_wdata[SW-1:0]` is used at addr 1.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high. The top level drives it as `~rst_n`.
- `cfg_we` in 1: config write strobe, one cycle per write.
- `cfg_addr` in 2: register address.
- `cfg_wdata` in 8: write data.
- `cfg_rdata` out 8: combinational readback of the register at `cfg_addr`.
- `start` in 1: begin a sweep. Single-cycle pulse or level; sampled only in IDLE.
- `abort` in 1: terminate the sweep.
- `cmp_in` in 1: comparator output from the analog macro, already synchronised upstream.
- `ch_sel` out 4: one-hot analog switch enables.
- `sample` out 1: sample strobe to the analog macro.
- `busy` out 1: high while the sweep FSM is not in IDLE.
- `done` out 1: one-cycle pulse at the end of a sweep.

## Operation
- Registers:
  - addr0: `{cont, 3'b0, mask[3:0]}`.
  - addr1: `settle[SW-1:0]`.
  - addr2: `{4'b0, result[3:0]}`, read-only.
  - addr3: `{7'b0, busy}`, read-only.
- Writes to addr0/1 are dropped while `busy`=1. Writes to addr2/3 are always ignored.
- Reset values:
  - `mask`=0, `settle`=0, `cont`=0, `result`=0.
  - `ch_sel`=0, `sample`=0, `busy`=0, `done`=0.
  - FSM=IDLE.
- FSM states: IDLE, BREAK, SETTLE, SAMPLE.
- IDLE:
  - `start`=1 and `mask`≠0 -> BREAK. `cur` = lowest set bit of `mask`; `result` bits not set in `mask` are cleared.
  - `start`=1 and `mask`=0 -> stay in IDLE; `done` pulses the next cycle; `result` is unchanged.
- BREAK: `ch_sel`=0 for exactly 1 cycle. Load the settle counter with `max(settle,1)`, then -> SETTLE.
- SETTLE: `ch_sel`=onehot(`cur`). Decrement the counter; when it reaches 1 -> SAMPLE. Duration is `max(settle,1)` cycles.
- SAMPLE: `ch_sel`=onehot(`cur`), `sample`=1 for 1 cycle. At the closing edge, `result[cur]` <= `cmp_in`.
  - Another set `mask` bit above `cur` -> `cur` = next higher set bit; go to BREAK.
  - Otherwise, end of sweep: go to IDLE with `done`=1 for one cycle (see Configuration for `cont`).
- Channel order is strictly ascending index; unset channels are skipped and take no cycles.
- `abort`=1 in any non-IDLE state -> IDLE at the next edge.
  - `ch_sel`=0, `sample`=0, no `done`.
  - `result` keeps the bits already captured.
  - `abort` has priority over every other transition, including the SAMPLE capture in the same cycle: no capture occurs.
- `start` while `busy` is ignored. `start` and `abort` together in IDLE: `abort` has no effect and the sweep starts.
- `ch_sel` is never multi-hot, and it is 0 for at least one cycle between two different channels.

## Timing
- All outputs are registered except `cfg_rdata`.
- `start` sampled at edge t0 -> BREAK during cycle t0+1; `ch_sel` goes high at t0+2.
- Per channel: N+2 cycles, where N=`max(settle,1)`.
- Sweep of k channels: `busy` is high for k·(N+2) cycles; `done` is high in the first IDLE cycle after the final SAMPLE.
- `result` is updated at the same edge that `done` rises (last channel).
- `rst` asserted mid-sweep: all outputs return to their reset values at the next edge.

## Configuration
- `JNW_ANA_SEQ_CONT_EN` defined:
  - `cont`=1 makes the last SAMPLE go to BREAK for the lowest mask bit instead of IDLE.
  - `done` pulses once per completed sweep (coincident with that BREAK cycle); `busy` stays 1.
  - `abort` or `rst` is the only exit.
- Not defined: `cont` bit reads 0, writes are discarded, one-shot only.

## Test plan
- Reset, then read addr0..3 -> all 0x00; `ch_sel`=0, `busy`=0.
- `mask`=0x5, `settle`=3, `cmp_in`=1, start:
  - `ch_sel` sequence: 0, 0001 ×4, 0, 0100 ×4.
  - `busy` 10 cycles; `done` one cycle after; addr2 reads 0x05.
- `mask`=0xF, `settle`=0, `cmp_in` toggling per cycle -> each channel takes 3 cycles; `result` matches `cmp_in` on each SAMPLE cycle; never multi-hot.
- `abort` during the SAMPLE of channel 2 with `mask`=0xF -> IDLE next edge, no `done`, `result[2]` unchanged, `result[1:0]` captured.
- Start with `mask`=0 -> `done` after 1 cycle, `busy` never high. Write addr1 while `busy` -> value unchanged.
- With `JNW_ANA_SEQ_CONT_EN`, `cont`=1, `mask`=0x2, `settle`=1 -> `done` every 3 cycles, `busy` stays 1; `abort` ends it. Without the macro, the same stimulus gives a single `done`.
